// File: rtl/useq_pkg.sv
// Shared types and control-store contents for the micro-sequencer of the
// ARM multicycle core.
package useq_pkg;

  typedef enum logic [4:0] {
    S_FETCH    = 5'd0,
    S_DECODE   = 5'd1,
    S_MEMADR   = 5'd2,
    S_MEMREAD  = 5'd3,
    S_MEMWB    = 5'd4,
    S_MEMWRITE = 5'd5,
    S_EXECR    = 5'd6,
    S_EXECI    = 5'd7,
    S_ALUWB    = 5'd8,
    S_BRANCH   = 5'd9,
    S_BL       = 5'd10,
    S_MEMREADB = 5'd11
  } ustate_e;

  // Next-field codes that ask the external dispatch logic for the target.
  localparam logic [4:0] DISP10 = 5'b11111;
  localparam logic [4:0] DISP11 = 5'b11110;

  localparam logic [4:0] ROM_DEPTH = 5'd12;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       alu_op;
    logic       alu_src_a;
    logic       adr_src;
    logic       byte_en;
    logic       mem_req;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
  } ctrl_word_t;

  typedef struct packed {
    logic [4:0] next;
    ctrl_word_t ctrl;
  } rom_entry_t;

  function automatic rom_entry_t mk(
    input logic [4:0] next,
    input logic pc_w, input logic ir_w, input logic reg_w, input logic mem_w,
    input logic br, input logic aop, input logic asa, input logic adr,
    input logic be, input logic mreq, input logic [1:0] asb, input logic [1:0] rs
  );
    rom_entry_t e;
    e.next            = next;
    e.ctrl.pc_write   = pc_w;
    e.ctrl.ir_write   = ir_w;
    e.ctrl.reg_write  = reg_w;
    e.ctrl.mem_write  = mem_w;
    e.ctrl.branch     = br;
    e.ctrl.alu_op     = aop;
    e.ctrl.alu_src_a  = asa;
    e.ctrl.adr_src    = adr;
    e.ctrl.byte_en    = be;
    e.ctrl.mem_req    = mreq;
    e.ctrl.alu_src_b  = asb;
    e.ctrl.result_src = rs;
    return e;
  endfunction

  //                       next    pc ir rw mw br ao sa ad be mr  srcb   res
  localparam rom_entry_t ROM [0:11] = '{
    mk(5'd1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10),
    mk(DISP10,1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10),
    mk(DISP11,1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00),
    mk(5'd4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00),
    mk(5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01),
    mk(5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00),
    mk(5'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00),
    mk(5'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00),
    mk(5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00),
    mk(5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10),
    mk(5'd9,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10),
    mk(5'd4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00)
  };

endpackage

// File: rtl/useq_rom.sv
// Combinational control store: micro-address to {next field, control word}.
// Unpopulated addresses decode to next=0 with every control deasserted.
module useq_rom
  import useq_pkg::*;
(
  input  logic [4:0] upc,
  output logic [4:0] next_field,
  output ctrl_word_t ctrl
);

  rom_entry_t entry;

  always_comb begin
    entry = '0;
    if (upc < ROM_DEPTH) entry = ROM[upc[3:0]];
  end

  assign next_field = entry.next;
  assign ctrl       = entry.ctrl;

endmodule

// File: rtl/micro_sequencer.sv
// Micro-PC register, stall handling and illegal-address detection around the
// control store. Performance counters exist only when USEQ_PERF_EN is defined.
module micro_sequencer
  import useq_pkg::*;
#(
  parameter int               UPC_W      = 5,
  parameter logic [UPC_W-1:0] RESET_UPC  = '0,
  parameter int               NUM_STATES = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       instr_op,
  input  logic [5:0]       instr_funct,
  input  logic             mem_ready,
  input  logic [UPC_W-1:0] real_next_adr,
  output logic [UPC_W-1:0] temp_next_adr,
  output logic [1:0]       disp_op,
  output logic [5:0]       disp_funct,
  output logic [UPC_W-1:0] upc,
  output logic             pc_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_write,
  output logic             branch,
  output logic             alu_op,
  output logic             alu_src_a,
  output logic             adr_src,
  output logic             byte_en,
  output logic             mem_req,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic             instr_done,
  output logic             illegal,
  output logic [31:0]      instr_count,
  output logic [31:0]      stall_count
);

  localparam logic [UPC_W-1:0] STATES_LIMIT = UPC_W'(NUM_STATES);

  ctrl_word_t       ctrl;
  logic [UPC_W-1:0] next_field;
  logic [UPC_W-1:0] upc_next;
  logic [1:0]       op_q;
  logic [5:0]       funct_q;
  logic             stall;
  logic             bad_target;
  logic             illegal_next;
  logic             done_next;
  logic             illegal_reg;
  logic             done_reg;

  useq_rom u_rom (
    .upc        (upc),
    .next_field (next_field),
    .ctrl       (ctrl)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upc         <= RESET_UPC;
      op_q        <= '0;
      funct_q     <= '0;
      illegal_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      upc         <= upc_next;
      illegal_reg <= illegal_next;
      done_reg    <= done_next;
      if (!stall && upc == S_DECODE) begin
        op_q    <= instr_op;
        funct_q <= instr_funct;
      end
    end
  end

  // Next-state logic; a stall freezes the micro-PC and suppresses both pulses.
  always_comb begin
    stall        = ctrl.mem_req && !mem_ready;
    bad_target   = (upc >= STATES_LIMIT) || (real_next_adr == DISP10) ||
                   (real_next_adr == DISP11);
    illegal_next = !stall && bad_target;
    done_next    = !stall && (next_field == '0);
    upc_next     = real_next_adr;
    if (stall)           upc_next = upc;
    else if (bad_target) upc_next = RESET_UPC;
  end

  // Outputs
  always_comb begin
    temp_next_adr = next_field;
    disp_op       = op_q;
    disp_funct    = funct_q;
    if (upc == S_DECODE) begin
      disp_op    = instr_op;
      disp_funct = instr_funct;
    end
    pc_write   = ctrl.pc_write;
    ir_write   = ctrl.ir_write;
    reg_write  = ctrl.reg_write;
    mem_write  = ctrl.mem_write;
    branch     = ctrl.branch;
    alu_op     = ctrl.alu_op;
    alu_src_a  = ctrl.alu_src_a;
    adr_src    = ctrl.adr_src;
    byte_en    = ctrl.byte_en;
    mem_req    = ctrl.mem_req;
    alu_src_b  = ctrl.alu_src_b;
    result_src = ctrl.result_src;
    instr_done = done_reg;
    illegal    = illegal_reg;
  end

`ifdef USEQ_PERF_EN
  logic [31:0] instr_count_reg;
  logic [31:0] stall_count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_count_reg <= '0;
      stall_count_reg <= '0;
    end else begin
      if (done_reg) instr_count_reg <= instr_count_reg + 32'd1;
      if (stall)    stall_count_reg <= stall_count_reg + 32'd1;
    end
  end

  assign instr_count = instr_count_reg;
  assign stall_count = stall_count_reg;
`else
  assign instr_count = 32'd0;
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: table-driven instruction flows with
// an attached dispatch model, plus stall, illegal-address and reset corners.
module tb_micro_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  instr_op;
  logic [5:0]  instr_funct;
  logic        mem_ready;
  logic [4:0]  real_next_adr;
  logic [4:0]  temp_next_adr;
  logic [1:0]  disp_op;
  logic [5:0]  disp_funct;
  logic [4:0]  upc;
  logic        pc_write, ir_write, reg_write, mem_write, branch, alu_op;
  logic        alu_src_a, adr_src, byte_en, mem_req;
  logic [1:0]  alu_src_b, result_src;
  logic        instr_done, illegal;
  logic [31:0] instr_count, stall_count;

  logic        force_en  = 1'b0;
  logic [4:0]  force_adr = 5'd0;

  int checks = 0;
  int errors = 0;

  micro_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .instr_op      (instr_op),
    .instr_funct   (instr_funct),
    .mem_ready     (mem_ready),
    .real_next_adr (real_next_adr),
    .temp_next_adr (temp_next_adr),
    .disp_op       (disp_op),
    .disp_funct    (disp_funct),
    .upc           (upc),
    .pc_write      (pc_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .mem_write     (mem_write),
    .branch        (branch),
    .alu_op        (alu_op),
    .alu_src_a     (alu_src_a),
    .adr_src       (adr_src),
    .byte_en       (byte_en),
    .mem_req       (mem_req),
    .alu_src_b     (alu_src_b),
    .result_src    (result_src),
    .instr_done    (instr_done),
    .illegal       (illegal),
    .instr_count   (instr_count),
    .stall_count   (stall_count)
  );

  always #5 clk = ~clk;

  // ARM multicycle dispatch tables (Decode -> DISP10, MemAdr -> DISP11).
  always_comb begin
    real_next_adr = temp_next_adr;
    if (temp_next_adr == 5'd31) begin
      case (disp_op)
        2'b00:   real_next_adr = disp_funct[5] ? 5'd7 : 5'd6;
        2'b01:   real_next_adr = 5'd2;
        2'b10:   real_next_adr = disp_funct[4] ? 5'd10 : 5'd9;
        default: real_next_adr = 5'd31;
      endcase
    end else if (temp_next_adr == 5'd30) begin
      real_next_adr = disp_funct[0] ? (disp_funct[2] ? 5'd11 : 5'd3) : 5'd5;
    end
    if (force_en) real_next_adr = force_adr;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // {mem_req, mem_write, reg_write, branch} expected in each microstate
  function automatic logic [3:0] exp_ctrl(input int s);
    logic [3:0] c;
    c = 4'b0000;
    case (s)
      0, 3, 11: c = 4'b1000;
      5:        c = 4'b1100;
      4, 8, 10: c = 4'b0010;
      9:        c = 4'b0001;
      default:  c = 4'b0000;
    endcase
    return c;
  endfunction

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [5:0] funct;
    int         len;
    int         seq [6];
  } vec_t;

  typedef struct {
    logic [4:0] upc;
    logic       done;
    logic [3:0] ctrl;
  } exp_t;

  vec_t vecs [7];
  exp_t sb [$];

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    mem_ready = 1'b1;
    force_en  = 1'b0;
  endtask

  task automatic push_exp(input int s, input logic done);
    exp_t e;
    e.upc  = 5'(s);
    e.done = done;
    e.ctrl = exp_ctrl(s);
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    $display("%s: upc=%0d exp=%0d done=%0d illegal=%0d", tag, upc, e.upc, instr_done, illegal);
    check({tag, " upc"}, 32'(upc), 32'(e.upc));
    check({tag, " instr_done"}, 32'(instr_done), 32'(e.done));
    check({tag, " illegal"}, 32'(illegal), 32'd0);
    check({tag, " ctrl"}, 32'({mem_req, mem_write, reg_write, branch}), 32'(e.ctrl));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    instr_op    = 2'b11;
    instr_funct = 6'b111111;
    mem_ready   = 1'b1;

    vecs[0] = '{"LDR",    2'b01, 6'b011001, 6, '{0, 1, 2, 3, 4, 0}};
    vecs[1] = '{"STR",    2'b01, 6'b000000, 5, '{0, 1, 2, 5, 0, 0}};
    vecs[2] = '{"LDRB",   2'b01, 6'b000101, 6, '{0, 1, 2, 11, 4, 0}};
    vecs[3] = '{"DP_IMM", 2'b00, 6'b100000, 5, '{0, 1, 7, 8, 0, 0}};
    vecs[4] = '{"DP_REG", 2'b00, 6'b000000, 5, '{0, 1, 6, 8, 0, 0}};
    vecs[5] = '{"BL",     2'b10, 6'b010000, 5, '{0, 1, 10, 9, 0, 0}};
    vecs[6] = '{"B",      2'b10, 6'b000000, 4, '{0, 1, 9, 0, 0, 0}};

    // Reset state while reset is held
    @(negedge clk);
    check("reset upc", 32'(upc), 32'd0);
    check("reset illegal", 32'(illegal), 32'd0);
    check("reset instr_done", 32'(instr_done), 32'd0);
    check("reset ir_write", 32'(ir_write), 32'd1);
    check("reset disp_op", 32'(disp_op), 32'd0);
    check("reset instr_count", instr_count, 32'd0);
    check("reset stall_count", stall_count, 32'd0);

    // Instruction flows
    for (int v = 0; v < 7; v++) begin
      do_reset();
      instr_op    = vecs[v].op;
      instr_funct = vecs[v].funct;
      for (int k = 0; k < vecs[v].len; k++)
        push_exp(vecs[v].seq[k], k == vecs[v].len - 1);
      for (int k = 0; k < vecs[v].len; k++) begin
        pop_check($sformatf("%s step %0d", vecs[v].name, k));
        if (k == 1) check({vecs[v].name, " decode disp_op"}, 32'(disp_op), 32'(vecs[v].op));
        if (k == 2) check({vecs[v].name, " held disp_funct"}, 32'(disp_funct), 32'(vecs[v].funct));
        @(posedge clk);
        #1;
        if (k == 1) begin
          instr_op    = ~vecs[v].op;
          instr_funct = ~vecs[v].funct;
        end
        @(negedge clk);
      end
    end

    // Three wait cycles in MemRead
    do_reset();
    instr_op    = 2'b01;
    instr_funct = 6'b011001;
    begin
      int sseq [9];
      sseq = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
      for (int k = 0; k < 9; k++) push_exp(sseq[k], k == 8);
      for (int k = 0; k < 9; k++) begin
        pop_check($sformatf("STALL step %0d", k));
        if (k == 7) begin
`ifdef USEQ_PERF_EN
          check("stall_count", stall_count, 32'd3);
`else
          check("stall_count tied", stall_count, 32'd0);
`endif
        end
        mem_ready = (k >= 3 && k <= 5) ? 1'b0 : 1'b1;
        @(posedge clk);
        @(negedge clk);
      end
    end
`ifdef USEQ_PERF_EN
    check("instr_count", instr_count, 32'd1);
`else
    check("instr_count tied", instr_count, 32'd0);
`endif

    // Dispatch returning no target from Fetch
    do_reset();
    force_adr = 5'd31;
    force_en  = 1'b1;
    @(posedge clk);
    #1 force_en = 1'b0;
    @(negedge clk);
    $display("ILLEGAL31: upc=%0d illegal=%0d", upc, illegal);
    check("disp31 upc", 32'(upc), 32'd0);
    check("disp31 illegal", 32'(illegal), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("disp31 upc after", 32'(upc), 32'd1);
    check("disp31 illegal once", 32'(illegal), 32'd0);

    // Jump to unpopulated entry 12, then the illegal recovery
    do_reset();
    force_adr = 5'd12;
    force_en  = 1'b1;
    @(posedge clk);
    #1 force_en = 1'b0;
    @(negedge clk);
    $display("UPC12: upc=%0d illegal=%0d next=%0d", upc, illegal, temp_next_adr);
    check("upc12 upc", 32'(upc), 32'd12);
    check("upc12 illegal", 32'(illegal), 32'd0);
    check("upc12 mem_req", 32'(mem_req), 32'd0);
    check("upc12 temp_next", 32'(temp_next_adr), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("upc12 recover upc", 32'(upc), 32'd0);
    check("upc12 recover illegal", 32'(illegal), 32'd1);

    // Reset arriving during a MemWrite stall
    do_reset();
    instr_op    = 2'b01;
    instr_funct = 6'b000000;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("rststall at memwrite", 32'(upc), 32'd5);
    mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rststall held", 32'(upc), 32'd5);
    #2 reset = 1'b1;
    #1;
    $display("RSTSTALL: upc=%0d mem_write=%0d ir_write=%0d", upc, mem_write, ir_write);
    check("rststall upc async", 32'(upc), 32'd0);
    check("rststall mem_write", 32'(mem_write), 32'd0);
    check("rststall ir_write", 32'(ir_write), 32'd1);
    @(negedge clk);
    reset     = 1'b0;
    mem_ready = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
